// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the memory/writeback stage: opcodes, trap causes
// and the trap FSM state type.
package riscv_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [31:0] CAUSE_LD_MISALIGN = 32'd4;
  localparam logic [31:0] CAUSE_ST_MISALIGN = 32'd6;

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} wb_state_t;

  function automatic logic writes_rd(input logic [6:0] opcode);
    case (opcode)
      LOAD, OP, OP_IMM, LUI, AUIPC, JAL, JALR: writes_rd = 1'b1;
      default:                                 writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_trap_ctrl.sv
// RUN/TRAP controller: latches the first misalignment fault into cause/epc/tval
// and holds the trap request until the control unit acknowledges it.
module wb_trap_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid,
  input  logic            err,
  input  logic            is_store,
  input  logic            trap_ack,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] addr,
  output logic            run,
  output logic            trap_req,
  output logic            flush,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mtval
);

  wb_state_t state_r;

  // Trap FSM with registered request/flush and frozen trap context while in TRAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= RUN;
      trap_req <= 1'b0;
      flush    <= 1'b0;
      mcause   <= '0;
      mepc     <= '0;
      mtval    <= '0;
    end else begin
      case (state_r)
        RUN: begin
          if (valid && err) begin
            state_r  <= TRAP;
            trap_req <= 1'b1;
            flush    <= 1'b1;
            mcause   <= is_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
            mepc     <= pc;
            mtval    <= addr;
          end
        end
        TRAP: begin
          if (trap_ack) begin
            state_r  <= RUN;
            trap_req <= 1'b0;
            flush    <= 1'b0;
          end
        end
        default: begin
          state_r  <= RUN;
          trap_req <= 1'b0;
          flush    <= 1'b0;
        end
      endcase
    end
  end

  assign run = (state_r == RUN);

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: S1 context register aligned with the registered dmem read,
// register-file writeback mux, retired-instruction counter and misalignment trap.
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 valid_in,
  input  logic [31:0]          instr_in,
  input  logic [XLEN-1:0]      pc_in,
  input  logic [XLEN-1:0]      alu_in,
  input  logic [XLEN-1:0]      f_addr_in,
  input  logic [XLEN-1:0]      dmem_dout,
  input  logic                 dmem_select,
  input  logic                 dmem_err,
  input  logic                 trap_ack,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 trap_req,
  output logic                 flush,
  output logic [XLEN-1:0]      mcause,
  output logic [XLEN-1:0]      mepc,
  output logic [XLEN-1:0]      mtval,
  output logic [XLEN-1:0]      instret
);

  logic                 valid_r;
  logic                 is_store_r;
  logic                 wb_en_r;
  logic [RF_ADDR_W-1:0] rd_r;
  logic [XLEN-1:0]      pc_r;
  logic [XLEN-1:0]      alu_r;
  logic [XLEN-1:0]      addr_r;
  logic [XLEN-1:0]      instret_r;
  logic [6:0]           opcode_s;
  logic                 run_s;
  logic                 retire_s;
  logic                 unused_s;

  assign opcode_s = instr_in[6:0];
  assign unused_s = ^instr_in[31:12];

  // S1 capture: valid drops while held so a stalled instruction retires once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r    <= 1'b0;
      is_store_r <= 1'b0;
      wb_en_r    <= 1'b0;
      rd_r       <= '0;
      pc_r       <= '0;
      alu_r      <= '0;
      addr_r     <= '0;
    end else begin
      valid_r <= en & valid_in;
      if (en) begin
        is_store_r <= (opcode_s == STORE);
        wb_en_r    <= writes_rd(opcode_s);
        rd_r       <= instr_in[7 +: RF_ADDR_W];
        pc_r       <= pc_in;
        alu_r      <= alu_in;
        addr_r     <= f_addr_in;
      end
    end
  end

  assign retire_s = valid_r & ~dmem_err & run_s;
  assign rf_we    = retire_s & wb_en_r & (rd_r != '0);
  assign rf_waddr = rd_r;
  assign rf_wdata = dmem_select ? dmem_dout : alu_r;

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_r <= '0;
    end else if (retire_s) begin
      instret_r <= instret_r + {{(XLEN-1){1'b0}}, 1'b1};
    end
  end

  assign instret = instret_r;

  wb_trap_ctrl #(.XLEN(XLEN)) u_trap_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (valid_r),
    .err      (dmem_err),
    .is_store (is_store_r),
    .trap_ack (trap_ack),
    .pc       (pc_r),
    .addr     (addr_r),
    .run      (run_s),
    .trap_req (trap_req),
    .flush    (flush),
    .mcause   (mcause),
    .mepc     (mepc),
    .mtval    (mtval)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expectations are pushed at EX presentation
// and popped on the following cycle when the dmem response is applied.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] instr_in = 32'h0;
  logic [31:0] pc_in = 32'h0;
  logic [31:0] alu_in = 32'h0;
  logic [31:0] f_addr_in = 32'h0;
  logic [31:0] dmem_dout = 32'h0;
  logic        dmem_select = 1'b0;
  logic        dmem_err = 1'b0;
  logic        trap_ack = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        trap_req;
  logic        flush;
  logic [31:0] mcause;
  logic [31:0] mepc;
  logic [31:0] mtval;
  logic [31:0] instret;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in), .instr_in(instr_in),
    .pc_in(pc_in), .alu_in(alu_in), .f_addr_in(f_addr_in), .dmem_dout(dmem_dout),
    .dmem_select(dmem_select), .dmem_err(dmem_err), .trap_ack(trap_ack),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .trap_req(trap_req),
    .flush(flush), .mcause(mcause), .mepc(mepc), .mtval(mtval), .instret(instret)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] O_LOAD = 7'b0000011, O_STORE = 7'b0100011, O_OP = 7'b0110011;
  localparam logic [6:0] O_IMM = 7'b0010011, O_LUI = 7'b0110111, O_AUIPC = 7'b0010111;
  localparam logic [6:0] O_JAL = 7'b1101111, O_JALR = 7'b1100111, O_BR = 7'b1100011;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        trap;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] tval;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  logic        m_trap = 1'b0;
  logic [31:0] m_cnt = 32'h0, m_cause = 32'h0, m_epc = 32'h0, m_tval = 32'h0;
  logic [31:0] p_dout = 32'h0;
  logic        p_sel = 1'b0, p_err = 1'b0, p_ack = 1'b0;

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd);
    mk = {20'h00000, rd, opc};
  endfunction

  function automatic logic m_wb(input logic [6:0] opc);
    m_wb = (opc == O_LOAD) || (opc == O_OP) || (opc == O_IMM) || (opc == O_LUI) ||
           (opc == O_AUIPC) || (opc == O_JAL) || (opc == O_JALR);
  endfunction

  // One cycle: present an EX instruction plus the dmem response of the previous one
  task automatic apply(input logic e, input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] addr,
                       input logic [31:0] dout, input logic sel, input logic err, input logic ack);
    exp_t x;
    exp_t y;
    logic ve;
    @(negedge clk);
    en = e; valid_in = v; instr_in = ins; pc_in = pc; alu_in = alu; f_addr_in = addr;
    dmem_dout = p_dout; dmem_select = p_sel; dmem_err = p_err; trap_ack = p_ack;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      n_vec++; if (rf_we !== x.we) begin n_err++; $display("FAIL rf_we: got %b want %b", rf_we, x.we); end
      n_vec++; if (trap_req !== x.trap) begin n_err++; $display("FAIL trap_req: got %b want %b", trap_req, x.trap); end
      n_vec++; if (flush !== x.trap) begin n_err++; $display("FAIL flush: got %b want %b", flush, x.trap); end
      n_vec++; if (instret !== x.cnt) begin n_err++; $display("FAIL instret: got %h want %h", instret, x.cnt); end
      n_vec++; if (mcause !== x.cause) begin n_err++; $display("FAIL mcause: got %h want %h", mcause, x.cause); end
      n_vec++; if (mepc !== x.epc) begin n_err++; $display("FAIL mepc: got %h want %h", mepc, x.epc); end
      n_vec++; if (mtval !== x.tval) begin n_err++; $display("FAIL mtval: got %h want %h", mtval, x.tval); end
      if (x.we) begin
        n_vec++; if (rf_waddr !== x.waddr) begin n_err++; $display("FAIL rf_waddr: got %0d want %0d", rf_waddr, x.waddr); end
        n_vec++; if (rf_wdata !== x.wdata) begin n_err++; $display("FAIL rf_wdata: got %h want %h", rf_wdata, x.wdata); end
      end
    end
    ve = e & v;
    y.trap  = m_trap;
    y.we    = ve & m_wb(ins[6:0]) & (ins[11:7] != 5'd0) & ~err & ~m_trap;
    y.waddr = ins[11:7];
    y.wdata = sel ? dout : alu;
    y.cnt   = m_cnt;
    y.cause = m_cause; y.epc = m_epc; y.tval = m_tval;
    sb.push_back(y);
    if (ve && !err && !m_trap) m_cnt = m_cnt + 32'd1;
    if (!m_trap) begin
      if (ve && err) begin
        m_trap = 1'b1;
        m_cause = (ins[6:0] == O_STORE) ? 32'd6 : 32'd4;
        m_epc = pc; m_tval = addr;
      end
    end else if (ack) begin
      m_trap = 1'b0;
    end
    p_dout = dout; p_sel = sel; p_err = err; p_ack = ack;
  endtask

  task automatic bubble(input logic ack);
    apply(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, ack);
  endtask

  task automatic test_reset();
    #2;
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    n_vec++; if (trap_req !== 1'b0) begin n_err++; $display("FAIL reset_trap_req: got %b want 0", trap_req); end
    n_vec++; if (instret !== 32'h0) begin n_err++; $display("FAIL reset_instret: got %h want 0", instret); end
    n_vec++; if (mcause !== 32'h0) begin n_err++; $display("FAIL reset_mcause: got %h want 0", mcause); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    apply(1'b1, 1'b1, mk(O_OP, 5'd5), 32'h10, 32'h00001234, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_load();
    apply(1'b1, 1'b1, mk(O_LOAD, 5'd7), 32'h14, 32'h00000100, 32'h100, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_x0_store();
    apply(1'b1, 1'b1, mk(O_IMM, 5'd0), 32'h18, 32'h00000055, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, mk(O_STORE, 5'd3), 32'h1C, 32'h00000200, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0);
    bubble(1'b0);
  endtask

  task automatic test_load_trap();
    apply(1'b1, 1'b1, mk(O_LOAD, 5'd8), 32'h40, 32'h102, 32'h102, 32'h0, 1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b1, mk(O_OP, 5'd9), 32'h44, 32'h77, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, mk(O_OP, 5'd10), 32'h48, 32'h88, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 1'b1, mk(O_OP, 5'd11), 32'h4C, 32'h99, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    bubble(1'b0);
  endtask

  task automatic test_store_trap_ack();
    apply(1'b1, 1'b1, mk(O_STORE, 5'd0), 32'h80, 32'h201, 32'h201, 32'h0, 1'b0, 1'b1, 1'b1);
    apply(1'b1, 1'b1, mk(O_LOAD, 5'd12), 32'h84, 32'h333, 32'h333, 32'h0, 1'b1, 1'b1, 1'b0);
    bubble(1'b0);
    bubble(1'b1);
    apply(1'b1, 1'b1, mk(O_LUI, 5'd13), 32'h88, 32'hABCD0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    bubble(1'b0);
  endtask

  task automatic test_hold();
    apply(1'b1, 1'b1, mk(O_OP, 5'd14), 32'hC0, 32'h5A5A5A5A, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      apply(1'b0, 1'b1, mk(O_OP, 5'd14), 32'hC0, 32'h5A5A5A5A, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    bubble(1'b0);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [9];
    ops = '{O_LOAD, O_STORE, O_OP, O_IMM, O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR};
    for (int i = 0; i < 30; i++) begin
      apply(($urandom_range(7) != 0) ? 1'b1 : 1'b0, ($urandom_range(7) != 0) ? 1'b1 : 1'b0,
            mk(ops[$urandom_range(8)], 5'($urandom_range(31))), $urandom, $urandom, $urandom,
            $urandom, 1'($urandom_range(1)), ($urandom_range(5) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(2) == 0) ? 1'b1 : 1'b0);
    end
    bubble(1'b1);
    bubble(1'b1);
    bubble(1'b0);
  endtask

  task automatic test_reset_in_trap();
    apply(1'b1, 1'b1, mk(O_LOAD, 5'd4), 32'h300, 32'h303, 32'h303, 32'h0, 1'b1, 1'b1, 1'b0);
    bubble(1'b0);
    bubble(1'b0);
    n_vec++; if (trap_req !== 1'b1) begin n_err++; $display("FAIL pre_reset_trap: got %b want 1", trap_req); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (trap_req !== 1'b0) begin n_err++; $display("FAIL async_trap_req: got %b want 0", trap_req); end
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL async_flush: got %b want 0", flush); end
    n_vec++; if (mcause !== 32'h0) begin n_err++; $display("FAIL async_mcause: got %h want 0", mcause); end
    n_vec++; if (mepc !== 32'h0) begin n_err++; $display("FAIL async_mepc: got %h want 0", mepc); end
    n_vec++; if (mtval !== 32'h0) begin n_err++; $display("FAIL async_mtval: got %h want 0", mtval); end
    n_vec++; if (instret !== 32'h0) begin n_err++; $display("FAIL async_instret: got %h want 0", instret); end
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL async_rf_we: got %b want 0", rf_we); end
    sb.delete();
    m_trap = 1'b0; m_cnt = 32'h0; m_cause = 32'h0; m_epc = 32'h0; m_tval = 32'h0;
    p_dout = 32'h0; p_sel = 1'b0; p_err = 1'b0; p_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 1'b1, mk(O_OP, 5'd2), 32'h400, 32'h0000BEEF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    bubble(1'b0);
    bubble(1'b0);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_x0_store();
    test_load_trap();
    test_store_trap_ack();
    test_hold();
    test_back_to_back();
    test_reset_in_trap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
